// File: rtl/mmio_timer_if.sv
// Data-memory-stage bus as seen by the timer: address, store data and strobe in,
// combinational read data and the interrupt request out.
interface mmio_timer_if;
  logic [31:0] a;
  logic [31:0] wData;
  logic        wEn;
  logic [31:0] v;
  logic        irq;

  modport master (output a, output wData, output wEn, input v, input irq);
  modport slave  (input a, input wData, input wEn, output v, output irq);
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer beside DM: CTRL/PRESET/COUNT in a 16-byte window,
// one-shot or auto-reload countdown, level or pulse interrupt request.
module mmio_timer #(
  parameter logic [31:0] BASE = 32'h0000_7F00
) (
  input logic        clk,
  input logic        reset,
  mmio_timer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        pending_q, pending_d;

  logic        hit;
  logic [1:0]  off;
  logic        wr_ctrl, wr_preset;
  logic        en, auto_mode, set_pending;
  logic [31:0] rdata;
  logic        unused_addr_bits;

  // Byte lane bits carry no meaning; every access is treated as a full word.
  assign unused_addr_bits = ^bus.a[1:0];

  assign hit       = (bus.a[31:4] == BASE[31:4]);
  assign off       = bus.a[3:2];
  assign wr_ctrl   = hit && bus.wEn && (off == 2'd0);
  assign wr_preset = hit && bus.wEn && (off == 2'd1);
  assign en        = ctrl_q[0];
  assign auto_mode = (ctrl_q[2:1] == 2'b01);

  always_comb begin
    rdata = '0;
    if (hit) begin
      case (off)
        2'd0:    rdata = {28'd0, ctrl_q};
        2'd1:    rdata = preset_q;
        2'd2:    rdata = count_q;
        default: rdata = '0;
      endcase
    end
  end

  assign bus.v   = rdata;
  assign bus.irq = ctrl_q[3] && (pending_q || (state_q == S_INT && auto_mode));

  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    preset_d    = preset_q;
    count_d     = count_q;
    set_pending = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (en) state_d = S_LOAD;
      end
      S_LOAD: begin
        count_d = preset_q;
        state_d = S_CNT;
      end
      S_CNT: begin
        if (!en) begin
          state_d = S_IDLE;
        end else if (count_q == 32'd0) begin
          state_d     = S_INT;
          set_pending = !auto_mode;
        end else begin
          count_d = count_q - 32'd1;
        end
      end
      S_INT: begin
        if (auto_mode) begin
          state_d = S_LOAD;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // CPU stores override the FSM's own CTRL update, but never swallow a new interrupt.
    if (wr_ctrl)   ctrl_d   = bus.wData[3:0];
    if (wr_preset) preset_d = bus.wData;

    if (set_pending)  pending_d = 1'b1;
    else if (wr_ctrl) pending_d = 1'b0;
    else              pending_d = pending_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ctrl_q    <= '0;
      preset_q  <= '0;
      count_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ctrl_q    <= ctrl_d;
      preset_q  <= preset_d;
      count_q   <= count_d;
      pending_q <= pending_d;
    end
  end

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: register access, one-shot, auto-reload, freeze,
// decode holes, zero preset, CTRL-write races and asynchronous reset.
module tb_mmio_timer;

  localparam logic [31:0] BASE   = 32'h0000_7F00;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PRE  = BASE + 32'h4;
  localparam logic [31:0] A_CNT  = BASE + 32'h8;
  localparam logic [31:0] A_UNM  = BASE + 32'hC;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #10 clk = ~clk;

  mmio_timer_if bus ();

  mmio_timer #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Index e holds the value after edge e+1 following the enabling CTRL write.
  int os_cnt [9]  = '{0, 5, 4, 3, 2, 1, 0, 0, 0};
  int os_irq [9]  = '{0, 0, 0, 0, 0, 0, 0, 1, 1};
  int ar_cnt [13] = '{0, 3, 2, 1, 0, 0, 0, 3, 2, 1, 0, 0, 0};
  int ar_irq [13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0};
  int nm_cnt [8]  = '{3, 3, 2, 1, 0, 0, 0, 3};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    bus.a     = addr;
    bus.wData = data;
    bus.wEn   = 1'b1;
    @(negedge clk);
    bus.wEn   = 1'b0;
    bus.wData = '0;
  endtask

  task automatic rdchk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] d;
    bus.a = addr;
    #1;
    d = bus.v;
    chk(tag, d, exp);
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset     = 1'b1;
    bus.a     = '0;
    bus.wData = '0;
    bus.wEn   = 1'b0;
    adv(2);
    reset = 1'b0;
    rdchk("rst_ctrl", A_CTRL, 32'h0);
    rdchk("rst_pre", A_PRE, 32'h0);
    rdchk("rst_cnt", A_CNT, 32'h0);
    rdchk("rst_unm", A_UNM, 32'h0);
    rdchk("rst_out", BASE + 32'h10, 32'h0);
    chk("rst_irq", {31'd0, bus.irq}, 32'h0);
    adv(1);

    // One-shot, PRESET = 5, IM set
    wr(A_PRE, 32'd5);
    rdchk("os_pre", A_PRE, 32'd5);
    wr(A_CTRL, 32'h9);
    for (int e = 0; e < 9; e++) begin
      adv(1);
      rdchk($sformatf("os_cnt_e%0d", e + 1), A_CNT, os_cnt[e]);
      chk($sformatf("os_irq_e%0d", e + 1), {31'd0, bus.irq}, os_irq[e]);
    end
    rdchk("os_ctrl_e9", A_CTRL, 32'h8);
    adv(2);
    chk("os_irq_hold", {31'd0, bus.irq}, 32'h1);
    wr(A_CTRL, 32'h8);
    chk("os_irq_clr", {31'd0, bus.irq}, 32'h0);

    // Auto-reload, PRESET = 3, IM set
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int e = 0; e < 13; e++) begin
      adv(1);
      rdchk($sformatf("ar_cnt_e%0d", e + 1), A_CNT, ar_cnt[e]);
      chk($sformatf("ar_irq_e%0d", e + 1), {31'd0, bus.irq}, ar_irq[e]);
    end

    // Auto-reload with IM clear
    wr(A_CTRL, 32'h0);
    adv(1);
    wr(A_CTRL, 32'h3);
    for (int e = 0; e < 8; e++) begin
      adv(1);
      rdchk($sformatf("nm_cnt_e%0d", e + 1), A_CNT, nm_cnt[e]);
      chk($sformatf("nm_irq_e%0d", e + 1), {31'd0, bus.irq}, 32'h0);
    end

    // Freeze mid-count and restart from PRESET
    wr(A_CTRL, 32'h0);
    adv(1);
    rdchk("frz_stop", A_CNT, 32'd2);
    wr(A_PRE, 32'd10);
    wr(A_CTRL, 32'h1);
    adv(6);
    rdchk("frz_at6", A_CNT, 32'd6);
    wr(A_CTRL, 32'h0);
    adv(2);
    rdchk("frz_cnt", A_CNT, 32'd5);
    rdchk("frz_ctrl", A_CTRL, 32'h0);
    wr(A_CTRL, 32'h1);
    adv(1);
    rdchk("frz_load", A_CNT, 32'd5);
    adv(1);
    rdchk("frz_reload", A_CNT, 32'd10);
    wr(A_CTRL, 32'h0);
    adv(1);

    // Ignored and out-of-window stores
    wr(A_CNT, 32'h1234);
    wr(A_UNM, 32'hFFFF_FFFF);
    wr(BASE + 32'h20, 32'hF);
    wr(BASE + 32'h24, 32'h55);
    rdchk("ign_ctrl", A_CTRL, 32'h0);
    rdchk("ign_pre", A_PRE, 32'd10);
    rdchk("ign_cnt", A_CNT, 32'd9);
    rdchk("ign_unm", A_UNM, 32'h0);
    adv(1);
    rdchk("ign_out", BASE + 32'h20, 32'h0);
    chk("ign_irq", {31'd0, bus.irq}, 32'h0);

    // PRESET = 0 one-shot, then CTRL-write races
    wr(A_PRE, 32'd0);
    wr(A_CTRL, 32'h9);
    adv(1);
    rdchk("z_cnt_e1", A_CNT, 32'd9);
    chk("z_irq_e1", {31'd0, bus.irq}, 32'h0);
    adv(1);
    rdchk("z_cnt_e2", A_CNT, 32'd0);
    chk("z_irq_e2", {31'd0, bus.irq}, 32'h0);
    adv(1);
    chk("z_irq_e3", {31'd0, bus.irq}, 32'h1);
    wr(A_CTRL, 32'h9);
    rdchk("race_cpu_ctrl", A_CTRL, 32'h9);
    chk("race_cpu_irq", {31'd0, bus.irq}, 32'h0);
    adv(2);
    chk("race_e6_irq", {31'd0, bus.irq}, 32'h0);
    wr(A_CTRL, 32'h9);
    chk("race_pend_irq", {31'd0, bus.irq}, 32'h1);
    rdchk("race_pend_ctrl", A_CTRL, 32'h9);
    adv(1);
    rdchk("race_os_ctrl", A_CTRL, 32'h8);
    chk("race_os_irq", {31'd0, bus.irq}, 32'h1);

    // Asynchronous reset between edges
    reset = 1'b1;
    #1;
    chk("arst_irq", {31'd0, bus.irq}, 32'h0);
    rdchk("arst_ctrl", A_CTRL, 32'h0);
    reset = 1'b0;
    adv(1);
    wr(A_PRE, 32'd100);
    wr(A_CTRL, 32'h9);
    adv(5);
    rdchk("arst_run", A_CNT, 32'd97);
    reset = 1'b1;
    #1;
    rdchk("arst_cnt", A_CNT, 32'h0);
    rdchk("arst_pre", A_PRE, 32'h0);
    reset = 1'b0;
    adv(2);
    rdchk("arst_cnt_after", A_CNT, 32'h0);
    rdchk("arst_ctrl_after", A_CTRL, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
